// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an external 8:1 mux select and assembles its eight outputs into one byte
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a scan (IDLE, or the HOLD transfer cycle)
//   abort      : cancel a scan in progress
//   mux_o      : external mux output
//   sel        : registered mux select
//   busy       : scan in progress
//   word_out   : assembled word, bit i from channel i
//   word_valid : word_out holds a completed scan
//   word_ready : downstream accepts word_out
module mux_scan_sequencer #(
   parameter int DWELL      = 2,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       mux_o,
   output logic [2:0] sel,
   output logic       busy,
   output logic [7:0] word_out,
   output logic       word_valid,
   input  logic       word_ready
);
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
   localparam logic [3:0] LAST = 4'(DWELL - 1);
   state_t     r_state, w_state_nx;
   logic [2:0] r_sel, w_sel_nx;
   logic [3:0] r_dwell, w_dwell_nx;
   logic [7:0] r_shadow, w_shadow_nx, w_shadow_smp;
   logic [7:0] r_word, w_word_nx;
   logic       r_valid, w_valid_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sel    <= '0;
         r_dwell  <= '0;
         r_shadow <= '0;
         r_word   <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_sel    <= w_sel_nx;
         r_dwell  <= w_dwell_nx;
         r_shadow <= w_shadow_nx;
         r_word   <= w_word_nx;
         r_valid  <= w_valid_nx;
      end
   end
   always_comb begin
      w_state_nx          = r_state;
      w_sel_nx            = r_sel;
      w_dwell_nx          = r_dwell;
      w_shadow_nx         = r_shadow;
      w_word_nx           = r_word;
      w_valid_nx          = r_valid;
      w_shadow_smp        = r_shadow;
      w_shadow_smp[r_sel] = mux_o;
      case (r_state)
         IDLE: if (start) begin
            w_state_nx  = SCAN;
            w_sel_nx    = '0;
            w_dwell_nx  = '0;
            w_shadow_nx = '0;
         end
         SCAN: begin
            // abort outranks a sample landing in the same cycle
            if (abort) begin
               w_state_nx  = IDLE;
               w_sel_nx    = '0;
               w_dwell_nx  = '0;
               w_shadow_nx = '0;
            end else if (r_dwell == LAST) begin
               w_shadow_nx = w_shadow_smp;
               w_dwell_nx  = '0;
               if (r_sel == 3'd7) begin
                  w_word_nx  = w_shadow_smp;
                  w_valid_nx = 1'b1;
                  w_sel_nx   = '0;
                  w_state_nx = HOLD;
               end else begin
                  w_sel_nx = r_sel + 3'd1;
               end
            end else begin
               w_dwell_nx = r_dwell + 4'd1;
            end
         end
         HOLD: if (r_valid && word_ready) begin
            w_valid_nx  = 1'b0;
            w_state_nx  = (CONTINUOUS || start) ? SCAN : IDLE;
            w_sel_nx    = '0;
            w_dwell_nx  = '0;
            w_shadow_nx = '0;
         end
         default: w_state_nx = IDLE;
      endcase
   end
   assign sel        = r_sel;
   assign busy       = (r_state == SCAN);
   assign word_out   = r_word;
   assign word_valid = r_valid;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboard bench for three sequencer configurations (D2, D1, D2 continuous)
module tb_mux_scan_sequencer;
   typedef struct packed {logic [7:0] w; int r;} exp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start[3], abort[3], ready[3], mux_o[3], valid[3], busy[3];
   logic [2:0] sel[3];
   logic [7:0] word[3], data[3];
   exp_t       q[3][$];
   int         cyc = 0, errors = 0, checks = 0, k = 0;
   int         rise[3];
   logic       pv[3];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mux_scan_sequencer #(.DWELL(2), .CONTINUOUS(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .mux_o(mux_o[0]), .sel(sel[0]), .busy(busy[0]), .word_out(word[0]), .word_valid(valid[0]), .word_ready(ready[0]));
   mux_scan_sequencer #(.DWELL(1), .CONTINUOUS(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .mux_o(mux_o[1]), .sel(sel[1]), .busy(busy[1]), .word_out(word[1]), .word_valid(valid[1]), .word_ready(ready[1]));
   mux_scan_sequencer #(.DWELL(2), .CONTINUOUS(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
      .mux_o(mux_o[2]), .sel(sel[2]), .busy(busy[2]), .word_out(word[2]), .word_valid(valid[2]), .word_ready(ready[2]));
   assign mux_o[0] = data[0][sel[0]];
   assign mux_o[1] = data[1][sel[1]];
   assign mux_o[2] = data[2][sel[2]];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input int i, input logic [7:0] w, input int r);
      exp_t e;
      e.w = w;
      e.r = r;
      q[i].push_back(e);
   endtask
   // monitor: pops the scoreboard on every handshake and checks word and rise cycle
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         if (valid[i] && !pv[i]) rise[i] = cyc;
         pv[i] = valid[i];
         if (valid[i] && ready[i]) begin
            if (q[i].size() == 0) chk($sformatf("u%0d_unexpected_word", i), 1, 0);
            else begin
               e = q[i].pop_front();
               chk($sformatf("u%0d_word", i), word[i], e.w);
               chk($sformatf("u%0d_rise_cycle", i), rise[i], e.r);
            end
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 3; i++) begin
         start[i] = 0; abort[i] = 0; ready[i] = 0; data[i] = 0; pv[i] = 0; rise[i] = 0;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_sel", sel[i], 0);
         chk("rst_busy", busy[i], 0);
         chk("rst_valid", valid[i], 0);
         chk("rst_word", word[i], 0);
      end
      repeat (2) step();
      rst_n = 1;
      step();
      // u0: 0x55 pattern, sel sequencing, backpressure
      data[0] = 8'h55;
      start[0] = 1; k = cyc + 1; push(0, 8'h55, k + 16);
      step();
      start[0] = 0;
      for (int j = 0; j < 16; j++) begin
         chk("a_sel", sel[0], j / 2);
         chk("a_busy", busy[0], 1);
         chk("a_nvalid", valid[0], 0);
         step();
      end
      chk("a_valid", valid[0], 1);
      chk("a_busy_fall", busy[0], 0);
      chk("a_sel_hold", sel[0], 0);
      chk("a_word", word[0], 8'h55);
      data[0] = 8'h0F;
      for (int j = 0; j < 10; j++) begin
         step();
         chk("bp_word", word[0], 8'h55);
         chk("bp_valid", valid[0], 1);
      end
      ready[0] = 1;
      step();
      ready[0] = 0;
      chk("bp_valid_clr", valid[0], 0);
      chk("bp_idle", busy[0], 0);
      // u0: abort on the channel-4 sample edge
      data[0] = 8'hFF; ready[0] = 1;
      start[0] = 1; k = cyc + 1;
      step();
      start[0] = 0;
      repeat (9) step();
      abort[0] = 1;
      step();
      abort[0] = 0;
      chk("ab_busy", busy[0], 0);
      chk("ab_sel", sel[0], 0);
      chk("ab_valid", valid[0], 0);
      chk("ab_word", word[0], 8'h55);
      repeat (20) step();
      chk("ab_still_idle", busy[0], 0);
      chk("ab_no_word", valid[0], 0);
      ready[0] = 0;
      // u0: start beats abort in IDLE, abort ignored in HOLD, start in transfer cycle
      data[0] = 8'h3C;
      start[0] = 1; abort[0] = 1; k = cyc + 1; push(0, 8'h3C, k + 16);
      step();
      start[0] = 0; abort[0] = 0;
      chk("sa_busy", busy[0], 1);
      repeat (16) step();
      chk("sa_valid", valid[0], 1);
      abort[0] = 1;
      step();
      abort[0] = 0;
      chk("hold_abort_valid", valid[0], 1);
      chk("hold_abort_word", word[0], 8'h3C);
      chk("hold_abort_busy", busy[0], 0);
      ready[0] = 1; start[0] = 1;
      step();
      ready[0] = 0; start[0] = 0;
      chk("restart_valid", valid[0], 0);
      chk("restart_busy", busy[0], 1);
      chk("restart_sel", sel[0], 0);
      abort[0] = 1;
      step();
      abort[0] = 0;
      chk("restart_abort", busy[0], 0);
      // u1: DWELL=1, 0xA3, start held high
      data[1] = 8'hA3;
      start[1] = 1; k = cyc + 1; push(1, 8'hA3, k + 8);
      step();
      for (int j = 0; j < 8; j++) begin
         chk("d1_sel", sel[1], j);
         chk("d1_busy", busy[1], 1);
         step();
      end
      chk("d1_valid", valid[1], 1);
      chk("d1_word", word[1], 8'hA3);
      chk("d1_busy_fall", busy[1], 0);
      step();
      chk("d1_hold_busy", busy[1], 0);
      chk("d1_hold_valid", valid[1], 1);
      start[1] = 0; ready[1] = 1;
      step();
      ready[1] = 0;
      chk("d1_valid_clr", valid[1], 0);
      chk("d1_idle", busy[1], 0);
      // u2: continuous, 0xFF then 0x00, 17-cycle period
      data[2] = 8'hFF; ready[2] = 1;
      start[2] = 1; k = cyc + 1; push(2, 8'hFF, k + 16); push(2, 8'h00, k + 33);
      step();
      start[2] = 0;
      repeat (16) step();
      chk("c_valid1", valid[2], 1);
      data[2] = 8'h00;
      step();
      chk("c_pulse", valid[2], 0);
      chk("c_rescan", busy[2], 1);
      chk("c_sel", sel[2], 0);
      repeat (16) step();
      chk("c_valid2", valid[2], 1);
      step();
      ready[2] = 0;
      chk("c_continue", busy[2], 1);
      // u0: async reset mid-scan on channel 5
      data[0] = 8'hFF;
      start[0] = 1; k = cyc + 1;
      step();
      start[0] = 0;
      repeat (11) step();
      chk("r_sel5", sel[0], 5);
      #2 rst_n = 0;
      #1;
      chk("ar_sel", sel[0], 0);
      chk("ar_busy", busy[0], 0);
      chk("ar_valid", valid[0], 0);
      chk("ar_word", word[0], 0);
      chk("ar_word_u1", word[1], 0);
      chk("ar_busy_u2", busy[2], 0);
      @(negedge clk);
      rst_n = 1;
      repeat (6) step();
      chk("ar_needs_start", busy[0], 0);
      chk("ar_idle_sel", sel[0], 0);
      data[0] = 8'hC9;
      start[0] = 1; k = cyc + 1; push(0, 8'hC9, k + 16);
      step();
      start[0] = 0;
      repeat (16) step();
      chk("ar_new_valid", valid[0], 1);
      ready[0] = 1;
      step();
      ready[0] = 0;
      chk("ar_new_clr", valid[0], 0);
      repeat (3) step();
      for (int i = 0; i < 3; i++) chk($sformatf("u%0d_queue_empty", i), q[i].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
